// File: rtl/stack_op_sequencer_if.sv
// Bundle between the bytecode decoder / stack memory and the operand-stack
// sequencer.
//   op_*   : decoder side. Instruction handshake, completion pulse, result, depth.
//   stk_*  : stack memory side. One push/pop transaction per stk_trigger pulse,
//            finished by stk_done.
// Modports:
//   slave  : the sequencer's view.
//   master : the environment's view. The environment drives op_* requests and
//            the stack's replies.
interface stack_op_sequencer_if #(
    parameter int STACKDATA = 32,
    parameter int STACKSIZE = 65_536
);
    localparam int DEPTHW = $clog2(STACKSIZE + 1);

    logic                 op_valid;
    logic [2:0]           op_code;
    logic [STACKDATA-1:0] op_imm;
    logic                 op_ready;
    logic                 op_done;
    logic                 op_error;
    logic [STACKDATA-1:0] result;
    logic [DEPTHW-1:0]    depth;

    logic                 stk_push;
    logic                 stk_trigger;
    logic [STACKDATA-1:0] stk_writevalue;
    logic [STACKDATA-1:0] stk_readvalue;
    logic                 stk_done;

    modport slave (
        input  op_valid, op_code, op_imm, stk_readvalue, stk_done,
        output op_ready, op_done, op_error, result, depth,
               stk_push, stk_trigger, stk_writevalue
    );

    modport master (
        output op_valid, op_code, op_imm, stk_readvalue, stk_done,
        input  op_ready, op_done, op_error, result, depth,
               stk_push, stk_trigger, stk_writevalue
    );
endinterface

// File: rtl/stack_op_sequencer.sv
// Operand-stack instruction sequencer.
// It accepts one instruction at a time from the decoder and checks the stack
// depth. It then runs the instruction as single push/pop transactions against
// the stack memory, with at most one transaction outstanding at a time.
// ALU results are computed on the popped operands and pushed back.
// Ports:
//   clk, rst : single clock. rst is asynchronous and active high.
//   bus      : stack_op_sequencer_if.slave. It carries the decoder handshake
//              (op_*, result, depth) and the stack port (stk_*).
// Opcodes: 000 PUSH, 001 POP, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR, 111 DUP.
module stack_op_sequencer #(
    parameter int STACKDATA = 32,
    parameter int STACKSIZE = 65_536
) (
    input  logic                   clk,
    input  logic                   rst,
    stack_op_sequencer_if.slave    bus
);
    localparam int DEPTHW = $clog2(STACKSIZE + 1);
    localparam logic [DEPTHW-1:0] DEPTH_FULL = DEPTHW'(STACKSIZE);
    localparam logic [DEPTHW-1:0] DEPTH_ONE  = DEPTHW'(1);

    localparam logic [2:0] OP_PUSH = 3'b000;
    localparam logic [2:0] OP_POP  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_DUP  = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE, S_POP1, S_W_POP1, S_POP2, S_W_POP2, S_EXEC,
        S_PUSH1, S_W_PUSH1, S_PUSH2, S_W_PUSH2, S_FIN, S_ERR
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [STACKDATA-1:0] a_q, a_d;
    logic [STACKDATA-1:0] b_q, b_d;
    // The value to push next and to report at FIN.
    // PUSH uses the immediate, POP/DUP the popped word, ALU ops the computed result.
    logic [STACKDATA-1:0] val_q, val_d;
    logic [STACKDATA-1:0] result_q, result_d;
    logic [DEPTHW-1:0]    depth_q, depth_d;

    // Accept-time depth check. It only looks at the incoming opcode and the
    // current depth.
    logic is_alu, need_one, underflow, overflow, accept_err;

    always_comb begin
        is_alu     = (bus.op_code == OP_ADD) || (bus.op_code == OP_SUB) ||
                     (bus.op_code == OP_AND) || (bus.op_code == OP_OR)  ||
                     (bus.op_code == OP_XOR);
        need_one   = (bus.op_code == OP_POP) || (bus.op_code == OP_DUP);
        underflow  = (is_alu   && ((depth_q == '0) || (depth_q == DEPTH_ONE))) ||
                     (need_one && (depth_q == '0));
        overflow   = ((bus.op_code == OP_PUSH) || (bus.op_code == OP_DUP)) &&
                     (depth_q == DEPTH_FULL);
        accept_err = underflow || overflow;
    end

    // State register and datapath flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_PUSH;
            a_q      <= '0;
            b_q      <= '0;
            val_q    <= '0;
            result_q <= '0;
            depth_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            val_q    <= val_d;
            result_q <= result_d;
            depth_q  <= depth_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.op_valid) begin
                    if (accept_err)                  state_d = S_ERR;
                    else if (bus.op_code == OP_PUSH) state_d = S_PUSH1;
                    else                             state_d = S_POP1;
                end
            end
            S_POP1:   state_d = S_W_POP1;
            S_W_POP1: begin
                if (bus.stk_done) begin
                    if (op_q == OP_POP)      state_d = S_FIN;
                    else if (op_q == OP_DUP) state_d = S_PUSH1;
                    else                     state_d = S_POP2;
                end
            end
            S_POP2:   state_d = S_W_POP2;
            S_W_POP2: if (bus.stk_done) state_d = S_EXEC;
            S_EXEC:   state_d = S_PUSH1;
            S_PUSH1:  state_d = S_W_PUSH1;
            S_W_PUSH1: begin
                if (bus.stk_done) state_d = (op_q == OP_DUP) ? S_PUSH2 : S_FIN;
            end
            S_PUSH2:   state_d = S_W_PUSH2;
            S_W_PUSH2: if (bus.stk_done) state_d = S_FIN;
            S_FIN:     state_d = S_IDLE;
            S_ERR:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        val_d    = val_q;
        result_d = result_q;
        depth_d  = depth_q;
        case (state_q)
            S_IDLE: begin
                if (bus.op_valid && !accept_err) begin
                    op_d = bus.op_code;
                    if (bus.op_code == OP_PUSH) val_d = bus.op_imm;
                end
            end
            S_W_POP1: begin
                // The first pop gives b for ALU ops and the value for POP/DUP.
                if (bus.stk_done) begin
                    b_d   = bus.stk_readvalue;
                    val_d = bus.stk_readvalue;
                    if (depth_q != '0) depth_d = depth_q - DEPTH_ONE;
                end
            end
            S_W_POP2: begin
                if (bus.stk_done) begin
                    a_d = bus.stk_readvalue;
                    if (depth_q != '0) depth_d = depth_q - DEPTH_ONE;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_SUB:  val_d = a_q - b_q;
                    OP_AND:  val_d = a_q & b_q;
                    OP_OR:   val_d = a_q | b_q;
                    OP_XOR:  val_d = a_q ^ b_q;
                    default: val_d = a_q + b_q;
                endcase
            end
            S_W_PUSH1, S_W_PUSH2: begin
                if (bus.stk_done && (depth_q != DEPTH_FULL)) depth_d = depth_q + DEPTH_ONE;
            end
            default: ;
        endcase
        // Load result on the way into FIN so it is valid alongside op_done.
        if (state_d == S_FIN) result_d = val_d;
    end

    // Outputs are decoded from the state
    always_comb begin
        bus.op_ready       = 1'b0;
        bus.op_done        = 1'b0;
        bus.op_error       = 1'b0;
        bus.stk_trigger    = 1'b0;
        bus.stk_push       = 1'b0;
        bus.stk_writevalue = val_q;
        bus.result         = result_q;
        bus.depth          = depth_q;
        case (state_q)
            S_IDLE:           bus.op_ready = 1'b1;
            S_POP1, S_POP2:   bus.stk_trigger = 1'b1;
            S_PUSH1, S_PUSH2: begin
                bus.stk_trigger = 1'b1;
                bus.stk_push    = 1'b1;
            end
            S_FIN:            bus.op_done = 1'b1;
            S_ERR: begin
                bus.op_done  = 1'b1;
                bus.op_error = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_stack_op_sequencer.sv
module tb_stack_op_sequencer;
    localparam int SS = 4;
    localparam logic [2:0] PUSH = 3'b000, POP = 3'b001, ADD = 3'b010, SUB = 3'b011,
                           AND_ = 3'b100, OR_ = 3'b101, XOR_ = 3'b110, DUP = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stack_op_sequencer_if #(.STACKDATA(32), .STACKSIZE(SS)) bus ();
    stack_op_sequencer #(.STACKDATA(32), .STACKSIZE(SS)) dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stack memory model. stk_done comes 2 cycles after stk_trigger, and the
    // read data is held until then.
    logic [31:0] mem [0:7];
    int          sp;
    logic        d1, d2;
    logic [31:0] rv;
    assign bus.stk_done      = d2;
    assign bus.stk_readvalue = rv;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            d1 <= 1'b0; d2 <= 1'b0; sp <= 0; rv <= '0;
        end else begin
            d1 <= bus.stk_trigger;
            d2 <= d1;
            if (bus.stk_trigger && bus.stk_push && sp < 8) begin
                mem[sp] <= bus.stk_writevalue;
                sp <= sp + 1;
            end else if (bus.stk_trigger && !bus.stk_push && sp > 0) begin
                rv <= mem[sp-1];
                sp <= sp - 1;
            end
        end
    end

    // Trigger counter and scoreboard on op_done
    int trig_cnt = 0;
    typedef struct { logic [31:0] res; logic err; int dep; } sb_t;
    sb_t sb_q[$];
    always @(negedge clk) begin
        if (!rst && bus.stk_trigger) trig_cnt++;
        if (!rst && bus.op_done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_op_done", 64'd1, 64'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check("result", 64'(bus.result), 64'(e.res));
                check("op_error", 64'(bus.op_error), 64'(e.err));
                check("depth", 64'(bus.depth), 64'(e.dep));
            end
        end
    end

    typedef struct {
        logic [2:0] code; logic [31:0] imm;
        logic [31:0] res; logic err; int dep; int lat; int trig;
    } vec_t;
    vec_t vecs[$];

    task automatic wait_ready();
        int i;
        for (i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.op_ready) break;
        end
        if (i == 50) check("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        int t0;
        sb_t e;
        wait_ready();
        e.res = v.res; e.err = v.err; e.dep = v.dep;
        sb_q.push_back(e);
        t0 = trig_cnt;
        bus.op_valid = 1'b1; bus.op_code = v.code; bus.op_imm = v.imm;
        @(posedge clk);
        @(negedge clk);
        bus.op_valid = 1'b0;
        n = 1;
        while (!bus.op_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.op_done) check("done_timeout", 64'd0, 64'd1);
        check("latency", 64'(n), 64'(v.lat));
        check("trigger_count", 64'(trig_cnt - t0), 64'(v.trig));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.op_valid = 1'b0; bus.op_code = PUSH; bus.op_imm = '0;
        //             code  imm           res           err  dep lat trig
        vecs.push_back('{ADD,  32'd0,        32'd0,        1'b1, 0, 1,  0});
        vecs.push_back('{PUSH, 32'd5,        32'd5,        1'b0, 1, 4,  1});
        vecs.push_back('{PUSH, 32'd3,        32'd3,        1'b0, 2, 4,  1});
        vecs.push_back('{ADD,  32'd0,        32'd8,        1'b0, 1, 11, 3});
        vecs.push_back('{POP,  32'd0,        32'd8,        1'b0, 0, 4,  1});
        vecs.push_back('{PUSH, 32'd3,        32'd3,        1'b0, 1, 4,  1});
        vecs.push_back('{PUSH, 32'd5,        32'd5,        1'b0, 2, 4,  1});
        vecs.push_back('{SUB,  32'd0,        32'hFFFF_FFFE, 1'b0, 1, 11, 3});
        vecs.push_back('{POP,  32'd0,        32'hFFFF_FFFE, 1'b0, 0, 4,  1});
        vecs.push_back('{PUSH, 32'd1,        32'd1,        1'b0, 1, 4,  1});
        vecs.push_back('{PUSH, 32'd2,        32'd2,        1'b0, 2, 4,  1});
        vecs.push_back('{PUSH, 32'd3,        32'd3,        1'b0, 3, 4,  1});
        vecs.push_back('{PUSH, 32'd4,        32'd4,        1'b0, 4, 4,  1});
        vecs.push_back('{PUSH, 32'd9,        32'd4,        1'b1, 4, 1,  0});
        vecs.push_back('{DUP,  32'd0,        32'd4,        1'b1, 4, 1,  0});
        vecs.push_back('{AND_, 32'd0,        32'd0,        1'b0, 3, 11, 3});
        vecs.push_back('{OR_,  32'd0,        32'd2,        1'b0, 2, 11, 3});
        vecs.push_back('{XOR_, 32'd0,        32'd3,        1'b0, 1, 11, 3});
        vecs.push_back('{POP,  32'd0,        32'd3,        1'b0, 0, 4,  1});
        vecs.push_back('{POP,  32'd0,        32'd3,        1'b1, 0, 1,  0});
        vecs.push_back('{PUSH, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1, 4, 1});
        vecs.push_back('{DUP,  32'd0,        32'hDEAD_BEEF, 1'b0, 2, 10, 3});
        vecs.push_back('{POP,  32'd0,        32'hDEAD_BEEF, 1'b0, 1, 4,  1});
        vecs.push_back('{POP,  32'd0,        32'hDEAD_BEEF, 1'b0, 0, 4,  1});
        vecs.push_back('{PUSH, 32'd7,        32'd7,        1'b0, 1, 4,  1});
        vecs.push_back('{SUB,  32'd0,        32'd7,        1'b1, 1, 1,  0});
        vecs.push_back('{POP,  32'd0,        32'd7,        1'b0, 0, 4,  1});
        vecs.push_back('{DUP,  32'd0,        32'd7,        1'b1, 0, 1,  0});

        // Reset state
        #12;
        check("rst_op_ready", 64'(bus.op_ready), 64'd1);
        check("rst_op_done", 64'(bus.op_done), 64'd0);
        check("rst_op_error", 64'(bus.op_error), 64'd0);
        check("rst_trigger", 64'(bus.stk_trigger), 64'd0);
        check("rst_push", 64'(bus.stk_push), 64'd0);
        check("rst_writevalue", 64'(bus.stk_writevalue), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_depth", 64'(bus.depth), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during W_POP2 of an ADD
        run_vec('{PUSH, 32'd1, 32'd1, 1'b0, 1, 4, 1});
        run_vec('{PUSH, 32'd2, 32'd2, 1'b0, 2, 4, 1});
        wait_ready();
        bus.op_valid = 1'b1; bus.op_code = ADD; bus.op_imm = '0;
        @(posedge clk);
        @(negedge clk);
        bus.op_valid = 1'b0;
        repeat (4) @(negedge clk);     // cycle 5: waiting on the second pop
        check("pre_rst_depth", 64'(bus.depth), 64'd1);
        check("pre_rst_ready", 64'(bus.op_ready), 64'd0);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_op_ready", 64'(bus.op_ready), 64'd1);
        check("mid_rst_op_done", 64'(bus.op_done), 64'd0);
        check("mid_rst_trigger", 64'(bus.stk_trigger), 64'd0);
        check("mid_rst_result", 64'(bus.result), 64'd0);
        check("mid_rst_depth", 64'(bus.depth), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_vec('{PUSH, 32'd6, 32'd6, 1'b0, 1, 4, 1});
        run_vec('{POP,  32'd0, 32'd6, 1'b0, 0, 4, 1});

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
